// File: rtl/fetch_stage.sv
// Instruction fetch stage with PC and IF/ID pipeline register for the 16-bit core.
// Optional perf counters (perf_fetched/perf_bubbles) are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter int unsigned                   PC_WIDTH    = 16,
  parameter int unsigned                   INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]           RESET_PC    = 16'h0000,
  parameter logic [INSTR_WIDTH-1:0]        NOP_INSTR   = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc_plus2,
  output logic                   if_id_valid,
  output logic                   halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]            perf_fetched,
  output logic [15:0]            perf_bubbles
`endif
);

  localparam logic [PC_WIDTH-1:0] PC_STEP     = PC_WIDTH'(2);
  localparam logic [PC_WIDTH-1:0] RESET_PC_P2 = RESET_PC + PC_STEP;
  localparam logic [3:0]          OP_HLT      = 4'b1111;

  logic [PC_WIDTH-1:0]    r_pc;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [PC_WIDTH-1:0]    r_pc_plus2;
  logic                   r_valid;
  logic                   r_halted;

  logic [PC_WIDTH-1:0]    w_pc_plus2;
  logic [PC_WIDTH-1:0]    w_target_plus2;
  logic                   w_is_hlt;

  assign w_pc_plus2     = r_pc + PC_STEP;
  assign w_target_plus2 = branch_target + PC_STEP;
  assign w_is_hlt       = (imem_data[INSTR_WIDTH-1 -: 4] == OP_HLT);

  // Priority: rst > branch_taken > stall > halted > normal fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_instr    <= NOP_INSTR;
      r_pc_plus2 <= RESET_PC_P2;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
    end else if (branch_taken) begin
      r_pc       <= branch_target;
      r_instr    <= NOP_INSTR;
      r_pc_plus2 <= w_target_plus2;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
    end else if (stall) begin
      r_pc       <= r_pc;
      r_instr    <= r_instr;
      r_pc_plus2 <= r_pc_plus2;
      r_valid    <= r_valid;
      r_halted   <= r_halted;
    end else if (r_halted) begin
      r_instr    <= NOP_INSTR;
      r_valid    <= 1'b0;
    end else begin
      r_instr    <= imem_data;
      r_pc_plus2 <= w_pc_plus2;
      r_valid    <= 1'b1;
      // HLT enters IF/ID as a valid word, but the PC freezes on its address.
      if (w_is_hlt) begin
        r_halted <= 1'b1;
      end else begin
        r_pc     <= w_pc_plus2;
      end
    end
  end

  assign imem_addr      = r_pc;
  assign if_id_instr    = r_instr;
  assign if_id_pc_plus2 = r_pc_plus2;
  assign if_id_valid    = r_valid;
  assign halted         = r_halted;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_perf_fetched;
  logic [15:0] r_perf_bubbles;
  logic        w_fetch_valid;

  // Every non-reset cycle is either a valid load or a bubble (flush, halt drain, stall hold).
  assign w_fetch_valid = ~branch_taken & ~stall & ~r_halted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_bubbles <= '0;
    end else if (w_fetch_valid) begin
      if (r_perf_fetched != '1) r_perf_fetched <= r_perf_fetched + 16'd1;
    end else begin
      if (r_perf_bubbles != '1) r_perf_bubbles <= r_perf_bubbles + 16'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_bubbles = r_perf_bubbles;
`endif

endmodule
